mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_timer.sv | 35 +++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter: FSM state encoding,
// default bus widths and the wait-counter width.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_W     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Wait-cycle counter for the memory arbiter: cleared on grant, counts busy
// cycles without an ack, and flags when the count reaches the limit.
module arb_timer
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [WAIT_W-1:0] limit,
  output logic              expired
);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single memory port with one
// outstanding access and a wait timeout. Define MEM_ARBITER_ROUND_ROBIN_EN to
// replace fixed ls-over-fetch priority with last-owner round robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                err
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                err_q, err_d;

  logic ls_wins;
  logic grant_if, grant_ls;
  logic busy, expired, timer_en;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_ls_q = 1 when load/store owned the most recent grant
  logic last_ls_q, last_ls_d;

  assign ls_wins = ls_req & (~if_req | ~last_ls_q);

  always_comb begin
    last_ls_d = last_ls_q;
    if (grant_ls) begin
      last_ls_d = 1'b1;
    end else if (grant_if) begin
      last_ls_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ls_q <= 1'b0;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  assign ls_wins = ls_req;
`endif

  // Grants are combinational so the winner sees them in the request cycle.
  assign grant_ls = (state_q == IDLE) & ~rst & ls_wins;
  assign grant_if = (state_q == IDLE) & ~rst & if_req & ~ls_wins;
  assign busy     = (state_q != IDLE);
  assign timer_en = busy & ~mem_ack & ~expired;

  arb_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_if | grant_ls),
    .enable  (timer_en),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          state_d     = LS_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_wmask_d = ls_wmask;
        end else if (grant_if) begin
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
        end
      end
      IF_BUSY, LS_BUSY: begin
        // An ack in the expiry cycle still completes the access normally.
        if (mem_ack || expired) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = ~mem_ack;
          if (state_q == IF_BUSY) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_ack ? mem_rdata : '0;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
    end
  end

  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign err       = err_q;
  assign stall     = (ls_req & ~grant_ls) | (state_q == LS_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grants,
// memory-port activity, completion timing, read data, timeouts and stall.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [3:0]  ls_wmask = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state: one access in flight, described by its grant cycle,
  // its completion cycle and what the memory port must show meanwhile.
  logic [31:0] mem_model [16];
  int          cyc = 0;
  bit          act_busy = 0, own_ls = 0, tmo_hit = 0, last_ls = 0;
  int          g_cyc = 0, end_cyc = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rd = '0;
  bit          exp_we = 0;
  logic [3:0]  exp_wmask = '0;

  bit          if_pend = 0, ls_pend = 0, pls_we = 0;
  logic [31:0] pif_addr = '0, pls_addr = '0, pls_wdata = '0;
  logic [3:0]  pls_wmask = '0;
  int          p_new = 0, p_spur = 0, force_d = -2, n_txn = 0;

  task automatic one_cycle();
    bit busy_now, rv_now, win_ls, win_if;
    int d;
    @(posedge clk);
    #1;
    cyc++;
    if (!if_pend && $urandom_range(99) < p_new) begin
      if_pend  = 1;
      pif_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!ls_pend && $urandom_range(99) < p_new) begin
      ls_pend   = 1;
      pls_we    = 1'($urandom_range(1));
      pls_addr  = $urandom & 32'hFFFF_FFFC;
      pls_wdata = $urandom;
      pls_wmask = 4'($urandom);
    end
    if_req   = if_pend;
    if_addr  = if_pend ? pif_addr : $urandom;
    ls_req   = ls_pend;
    ls_we    = pls_we;
    ls_addr  = pls_addr;
    ls_wdata = pls_wdata;
    ls_wmask = pls_wmask;

    busy_now  = act_busy && cyc > g_cyc && cyc <= end_cyc;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (busy_now && !tmo_hit && cyc == end_cyc) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_model[exp_addr[5:2]];
      exp_rd    = mem_rdata;
      if (exp_we)
        for (int b = 0; b < 4; b++)
          if (exp_wmask[b]) mem_model[exp_addr[5:2]][8*b +: 8] = exp_wdata[8*b +: 8];
    end else if (!busy_now && $urandom_range(99) < p_spur) begin
      mem_ack = 1'b1;
    end

    @(negedge clk);
    rv_now = act_busy && cyc == end_cyc + 1;
    check_val("if_rvalid", if_rvalid, rv_now && !own_ls);
    check_val("ls_rvalid", ls_rvalid, rv_now && own_ls);
    check_val("err", err, rv_now && tmo_hit);
    if (rv_now) begin
      if (own_ls) check_val("ls_rdata", ls_rdata, exp_rd);
      else        check_val("if_rdata", if_rdata, exp_rd);
      $display("txn %0d %s addr=%h we=%0d latency=%0d timeout=%0d rdata=%h",
               n_txn, own_ls ? "ls" : "if", exp_addr, exp_we, cyc - g_cyc, tmo_hit, exp_rd);
      act_busy = 0;
    end
    check_val("mem_req", mem_req, busy_now);
    if (busy_now) begin
      check_val("mem_addr", mem_addr, exp_addr);
      check_val("mem_ctl", {mem_we, mem_wmask, mem_wdata}, {exp_we, exp_wmask, exp_wdata});
    end

    win_ls = 0;
    win_if = 0;
    if (!act_busy) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      win_ls = ls_pend && (!if_pend || !last_ls);
`else
      win_ls = ls_pend;
`endif
      win_if = if_pend && !win_ls;
    end
    check_val("if_gnt", if_gnt, win_if);
    check_val("ls_gnt", ls_gnt, win_ls);
    check_val("stall", stall, (ls_pend && !win_ls) || (busy_now && own_ls));

    if (win_if || win_ls) begin
      if (force_d != -2) d = force_d;
      else d = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(3));
      act_busy = 1;
      own_ls   = win_ls;
      g_cyc    = cyc;
      tmo_hit  = (d < 0);
      end_cyc  = (d < 0) ? cyc + 1 + TMO : cyc + 1 + d;
      exp_rd   = '0;
      n_txn++;
      if (win_ls) begin
        exp_addr = pls_addr; exp_we = pls_we; exp_wdata = pls_wdata; exp_wmask = pls_wmask;
        ls_pend = 0;
        last_ls = 1;
      end else begin
        exp_addr = pif_addr; exp_we = 0; exp_wdata = '0; exp_wmask = '0;
        if_pend = 0;
        last_ls = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;

    // Requests held during reset must not be granted.
    rst    = 1'b1;
    if_req = 1'b1;
    ls_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctl", {mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid, err}, '0);
    check_val("rst_addr", mem_addr, '0);
    check_val("rst_wdata", {mem_wmask, mem_wdata}, '0);
    check_val("rst_rdata", {if_rdata, ls_rdata}, '0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
    rst    = 1'b0;

    // Lone fetch at 0x100, ack 3 cycles after mem_req rises.
    if_pend = 1; pif_addr = 32'h100; force_d = 3;
    repeat (7) one_cycle();

    // Collision: load/store first, fetch granted in the rvalid cycle.
    ls_pend = 1; pls_we = 0; pls_addr = 32'h44; pls_wdata = '0; pls_wmask = '0;
    if_pend = 1; pif_addr = 32'h104; force_d = 1;
    repeat (8) one_cycle();

    // Store with partial mask.
    ls_pend = 1; pls_we = 1; pls_addr = 32'h40; pls_wdata = 32'hDEADBEEF; pls_wmask = 4'h3;
    force_d = 2;
    repeat (6) one_cycle();

    // Timeout, with a fetch waiting to prove the FSM is idle 6 cycles after grant.
    ls_pend = 1; pls_we = 0; pls_addr = 32'h48; force_d = -1;
    repeat (4) one_cycle();
    if_pend = 1; pif_addr = 32'h300; force_d = 0;
    repeat (6) one_cycle();

    // Spurious acks while idle.
    p_spur = 100;
    repeat (4) one_cycle();
    p_spur = 0;
    if_pend = 1; pif_addr = 32'h108; force_d = 0;
    repeat (3) one_cycle();

    // Random traffic.
    p_new = 35; p_spur = 25; force_d = -2;
    repeat (400) one_cycle();
    p_new = 0;
    repeat (20) one_cycle();

    // Reset in the middle of a load/store access.
    p_spur = 0;
    ls_pend = 1; pls_we = 0; pls_addr = 32'h80; force_d = -1;
    repeat (3) one_cycle();
    @(posedge clk);
    #2;
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
    #1;
    check_val("rst_mid_mem_req", mem_req, 1'b0);
    check_val("rst_mid_done", {ls_rvalid, if_rvalid, err}, '0);
    @(negedge clk);
    check_val("rst_hold", {mem_req, ls_rvalid, if_rvalid, err, ls_gnt, if_gnt}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    act_busy = 0; last_ls = 0; ls_pend = 0; if_pend = 0;
    @(negedge clk);
    check_val("rst_release", {mem_req, ls_rvalid, if_rvalid, err}, '0);
    if_pend = 1; pif_addr = 32'h200; force_d = 1;
    repeat (6) one_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
